// File: rtl/gost_cipher_engine_if.sv
// Host-side request/response bundle for the Magma block engine.
// slave is the engine side, master the host side.
interface gost_cipher_engine_if;
  logic         start;
  logic         enc_dec;
  logic [1:0]   mode_i;
  logic         init_i;
  logic [63:0]  iv_i;
  logic [255:0] key_i;
  logic [63:0]  data_i;
  logic [63:0]  data_o;
  logic         busy;
  logic         ready_o;
  logic         err_o;

  modport slave (
    input  start, enc_dec, mode_i, init_i,
    input  iv_i, key_i, data_i,
    output data_o, busy, ready_o, err_o
  );

  modport master (
    output start, enc_dec, mode_i, init_i,
    output iv_i, key_i, data_i,
    input  data_o, busy, ready_o, err_o
  );
endinterface

// File: rtl/gost_cipher_engine.sv
// Magma (GOST 28147-89 / R 34.12-2015) block engine, ECB/CBC/CTR.
// RPC rounds per clock; one extra cycle applies the chaining wrap.
module gost_cipher_engine #(
  parameter int RPC = 1
) (
  input logic clock,
  input logic reset,
  gost_cipher_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, RUN, FIN
  } state_t;

  localparam logic [1:0] ECB = 2'b00;
  localparam logic [1:0] CBC = 2'b01;
  localparam logic [1:0] CTR = 2'b10;

  // Row i holds pi_i with entry x at bits [4x+3:4x].
  localparam logic [63:0] SBOX [8] = '{
    64'h1F307D8E9B5A264C,
    64'hF0DB74E1C5A93286,
    64'h069C471EDAF2853B,
    64'hB9E35A076F4D128C,
    64'hC24BE390D618A5F7,
    64'h0E34187BAC296FD5,
    64'h73AD0B4FC19652E8,
    64'h2BC96AF43850DE71
  };

  state_t state_q, state_d;

  logic [255:0] key_q;
  logic [63:0]  data_q;
  logic [63:0]  blk_q;
  logic [63:0]  blk_d;
  logic [63:0]  chain_q;
  logic [63:0]  chain_d;
  logic [63:0]  out_d;
  logic [63:0]  c_use;
  logic [63:0]  core_in;
  logic         enc_q;
  logic [1:0]   mode_q;
  logic [5:0]   rnd_q;
  logic [5:0]   rnd_nx;
  logic         last;
  logic         illegal;
  logic         accept;
  logic [31:0]  a1, a0, t;
  logic [4:0]   r;

  function automatic logic [31:0] g(
    input logic [31:0] k,
    input logic [31:0] a
  );
    logic [31:0] s, p;
    s = a + k;
    p = '0;
    for (int i = 0; i < 8; i++)
      p[4*i +: 4] = SBOX[i][{s[4*i +: 4], 2'b00} +: 4];
    return {p[20:0], p[31:21]};
  endfunction

  function automatic logic [31:0] subkey(
    input logic [255:0] k,
    input logic [4:0]   rr,
    input logic         enc
  );
    logic [2:0] j, jn;
    logic       fwd;
    fwd = enc ? (rr < 5'd24) : (rr < 5'd8);
    j   = fwd ? rr[2:0] : ~rr[2:0];
    jn  = ~j;
    return k[{jn, 5'b0} +: 32];
  endfunction

  assign illegal = bus.mode_i == 2'b11;
  assign accept  = state_q == IDLE && bus.start && !illegal;
  assign c_use   = bus.init_i ? bus.iv_i : chain_q;
  assign rnd_nx  = rnd_q + 6'(RPC);
  assign last    = rnd_nx == 6'd32;
  assign bus.busy = state_q != IDLE;

  always_comb begin
    core_in = bus.data_i;
    unique case (1'b1)
      bus.mode_i == CBC && bus.enc_dec:
        core_in = bus.data_i ^ c_use;
      bus.mode_i == CTR:
        core_in = c_use;
      default: ;
    endcase
  end

  // Rounds rnd_q .. rnd_q+RPC-1; round 31 skips the swap.
  always_comb begin
    a1 = blk_q[63:32];
    a0 = blk_q[31:0];
    t  = '0;
    r  = '0;
    for (int i = 0; i < RPC; i++) begin
      r = rnd_q[4:0] + 5'(i);
      t = g(subkey(key_q, r, enc_q), a0) ^ a1;
      if (r == 5'd31) begin
        a1 = t;
      end else begin
        a1 = a0;
        a0 = t;
      end
    end
    blk_d = {a1, a0};
  end

  always_comb begin
    out_d   = blk_q;
    chain_d = chain_q;
    unique case (1'b1)
      mode_q == CBC && enc_q:
        chain_d = blk_q;
      mode_q == CBC && !enc_q: begin
        out_d   = blk_q ^ chain_q;
        chain_d = data_q;
      end
      mode_q == CTR: begin
        out_d   = blk_q ^ data_q;
        chain_d = chain_q + 64'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      key_q       <= '0;
      data_q      <= '0;
      blk_q       <= '0;
      chain_q     <= '0;
      enc_q       <= 1'b0;
      mode_q      <= ECB;
      rnd_q       <= '0;
      bus.data_o  <= '0;
      bus.ready_o <= 1'b0;
      bus.err_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus.err_o <= state_q == IDLE
                   && bus.start && illegal;
      if (accept) begin
        key_q       <= bus.key_i;
        data_q      <= bus.data_i;
        enc_q       <= bus.enc_dec
                       || bus.mode_i == CTR;
        mode_q      <= bus.mode_i;
        blk_q       <= core_in;
        rnd_q       <= '0;
        bus.ready_o <= 1'b0;
        if (bus.init_i) chain_q <= bus.iv_i;
      end else if (state_q == RUN) begin
        blk_q <= blk_d;
        rnd_q <= last ? 6'd0 : rnd_nx;
      end else if (state_q == FIN) begin
        bus.data_o  <= out_d;
        chain_q     <= chain_d;
        bus.ready_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gost_cipher_engine.sv
// Vector bench for gost_cipher_engine at RPC 1, 4 and 32.
// All three engines see the same stimulus.
module tb_gost_cipher_engine;

  localparam logic [1:0] ECB = 2'b00;
  localparam logic [1:0] CBC = 2'b01;
  localparam logic [1:0] CTR = 2'b10;
  localparam logic [255:0] KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [255:0] KEY2 =
    256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [63:0] PT = 64'hfedcba9876543210;
  localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0] D2 = 64'h0123456789abcdef;
  localparam logic [63:0] V2 = 64'h5a5a00ffc3c31234;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         start = 1'b0;
  logic         enc = 1'b0;
  logic [1:0]   mode = ECB;
  logic         init = 1'b0;
  logic [63:0]  iv = '0;
  logic [63:0]  data = '0;
  logic [255:0] key = '0;

  gost_cipher_engine_if b1 ();
  gost_cipher_engine_if b4 ();
  gost_cipher_engine_if b32 ();

  gost_cipher_engine #(.RPC(1)) u1 (
    .clock(clock), .reset(reset), .bus(b1.slave));
  gost_cipher_engine #(.RPC(4)) u4 (
    .clock(clock), .reset(reset), .bus(b4.slave));
  gost_cipher_engine #(.RPC(32)) u32 (
    .clock(clock), .reset(reset), .bus(b32.slave));

  always_comb begin
    b1.start = start;  b1.enc_dec = enc;  b1.mode_i = mode;
    b1.init_i = init;  b1.iv_i = iv;      b1.key_i = key;
    b1.data_i = data;
    b4.start = start;  b4.enc_dec = enc;  b4.mode_i = mode;
    b4.init_i = init;  b4.iv_i = iv;      b4.key_i = key;
    b4.data_i = data;
    b32.start = start; b32.enc_dec = enc; b32.mode_i = mode;
    b32.init_i = init; b32.iv_i = iv;     b32.key_i = key;
    b32.data_i = data;
  end

  logic [63:0] dout [3];
  logic        bsy [3];
  logic        rdy [3];
  logic        err [3];
  assign dout[0] = b1.data_o;  assign dout[1] = b4.data_o;
  assign dout[2] = b32.data_o;
  assign bsy[0] = b1.busy;     assign bsy[1] = b4.busy;
  assign bsy[2] = b32.busy;
  assign rdy[0] = b1.ready_o;  assign rdy[1] = b4.ready_o;
  assign rdy[2] = b32.ready_o;
  assign err[0] = b1.err_o;    assign err[1] = b4.err_o;
  assign err[2] = b32.err_o;

  int rpcs [3] = '{1, 4, 32};
  int lat_exp [3] = '{33, 9, 2};

  int sb [8][16] = '{
    '{12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1},
    '{6,8,2,3,9,10,5,12,1,14,4,7,11,13,0,15},
    '{11,3,5,8,2,15,10,13,14,1,7,4,12,9,6,0},
    '{12,8,2,1,13,4,15,6,7,0,10,5,3,14,9,11},
    '{7,15,5,10,8,1,6,13,0,9,3,14,11,4,2,12},
    '{5,13,15,6,9,2,12,10,11,7,8,1,4,3,14,0},
    '{8,14,2,5,6,9,1,12,15,4,11,0,13,10,3,7},
    '{1,7,14,13,0,5,8,3,4,15,10,6,9,12,11,2}
  };

  function automatic logic [63:0] magma(
    input logic [255:0] k,
    input logic [63:0]  b,
    input bit           e
  );
    logic [31:0] x1, x0, s, tt;
    int j;
    x1 = b[63:32];
    x0 = b[31:0];
    for (int rr = 0; rr < 32; rr++) begin
      if (e) j = (rr < 24) ? rr % 8 : 7 - rr % 8;
      else   j = (rr < 8)  ? rr % 8 : 7 - rr % 8;
      s = x0 + k[255 - 32*j -: 32];
      for (int n = 0; n < 8; n++)
        s[4*n +: 4] = 4'(sb[n][s[4*n +: 4]]);
      s  = {s[20:0], s[31:21]};
      tt = s ^ x1;
      if (rr == 31) return {tt, x0};
      x1 = x0;
      x0 = tt;
    end
    return '0;
  endfunction

  typedef struct {
    logic [1:0]   m;
    logic         e;
    logic         i;
    logic [63:0]  v;
    logic [255:0] k;
    logic [63:0]  d;
    logic [63:0]  x;
  } vec_t;

  vec_t tv [15];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bsy[0] | bsy[1] | bsy[2]) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("idle timeout", 64'd1, 64'd0);
  endtask

  task automatic go(input string nm, input vec_t v,
                    input bit scramble);
    int got [3];
    for (int q = 0; q < 3; q++) got[q] = 0;
    wait_idle();
    @(negedge clock);
    mode = v.m; enc = v.e; init = v.i;
    iv = v.v; key = v.k; data = v.d;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    init = 1'b0;
    chk($sformatf("%s busy@accept", nm), 64'(bsy[0]), 64'd1);
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock);
      #1;
      if (scramble && c == 3) begin
        key = ~key; data = ~data; iv = ~iv;
        enc = ~enc; mode = CBC;
      end
      for (int q = 0; q < 3; q++)
        if (got[q] == 0 && rdy[q]) got[q] = c;
      if (got[0] != 0 && got[1] != 0 && got[2] != 0) break;
    end
    for (int q = 0; q < 3; q++) begin
      chk($sformatf("%s rpc%0d latency", nm, rpcs[q]),
          64'(got[q]), 64'(lat_exp[q]));
      chk($sformatf("%s rpc%0d data", nm, rpcs[q]),
          dout[q], v.x);
    end
  endtask

  initial begin
    logic [63:0] e0, e1, c2, pd, pr;
    vec_t hv;
    int c;
    e0 = magma(KEY, 64'd0, 1'b1);
    e1 = magma(KEY, 64'd1, 1'b1);
    c2 = magma(KEY2, D2, 1'b1);
    tv[0]  = '{ECB, 1'b1, 1'b0, 64'd0, KEY, PT, CT};
    tv[1]  = '{ECB, 1'b0, 1'b0, 64'd0, KEY, CT, PT};
    tv[2]  = '{CBC, 1'b1, 1'b1, 64'd0, KEY, PT, CT};
    tv[3]  = '{CBC, 1'b1, 1'b0, 64'd0, KEY, CT, e0};
    tv[4]  = '{CBC, 1'b0, 1'b1, 64'd0, KEY, CT, PT};
    tv[5]  = '{CBC, 1'b0, 1'b0, 64'd0, KEY, e0, CT};
    tv[6]  = '{CTR, 1'b1, 1'b1, 64'd0, KEY, 64'd0, e0};
    tv[7]  = '{CTR, 1'b1, 1'b0, 64'd0, KEY, 64'd0, e1};
    tv[8]  = '{CTR, 1'b0, 1'b1, 64'd0, KEY, 64'd0, e0};
    tv[9]  = '{CTR, 1'b0, 1'b0, 64'd0, KEY, 64'd0, e1};
    tv[10] = '{ECB, 1'b1, 1'b0, 64'd0, KEY2, D2, c2};
    tv[11] = '{ECB, 1'b0, 1'b0, 64'd0, KEY2, c2, D2};
    tv[12] = '{CBC, 1'b1, 1'b1, V2, KEY2, D2,
               magma(KEY2, D2 ^ V2, 1'b1)};
    tv[13] = '{CTR, 1'b1, 1'b1, '1, KEY, D2,
               D2 ^ magma(KEY, '1, 1'b1)};
    tv[14] = '{CTR, 1'b1, 1'b0, 64'd0, KEY, D2, D2 ^ e0};

    #1;
    for (int q = 0; q < 3; q++) begin
      chk("reset busy", 64'(bsy[q]), 64'd0);
      chk("reset ready", 64'(rdy[q]), 64'd0);
      chk("reset data", dout[q], 64'd0);
      chk("reset err", 64'(err[q]), 64'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    for (int n = 0; n < 15; n++)
      go($sformatf("vec%0d", n), tv[n], 1'b0);

    hv = tv[0];
    go("key change mid-run", hv, 1'b1);

    // start held high: re-accept in the first idle cycle only
    wait_idle();
    @(negedge clock);
    mode = ECB; enc = 1'b1; key = KEY; data = PT;
    start = 1'b1;
    @(posedge clock);
    for (int rep = 0; rep < 2; rep++) begin
      c = 0;
      do begin
        @(posedge clock);
        #1;
        c++;
      end while (!rdy[0] && c < 40);
      chk($sformatf("held start lat%0d", rep), 64'(c), 64'd33);
      chk($sformatf("held start data%0d", rep), dout[0], CT);
      chk($sformatf("held start idle%0d", rep), 64'(bsy[0]), 64'd0);
      @(posedge clock);
      #1;
      chk($sformatf("held re-accept busy%0d", rep),
          64'(bsy[0]), 64'd1);
      chk($sformatf("held re-accept rdy%0d", rep),
          64'(rdy[0]), 64'd0);
    end
    @(negedge clock);
    start = 1'b0;

    wait_idle();
    @(negedge clock);
    pd = dout[0];
    pr = 64'(rdy[0]);
    mode = 2'b11;
    start = 1'b1;
    @(posedge clock);
    #1;
    for (int q = 0; q < 3; q++) begin
      chk("illegal err pulse", 64'(err[q]), 64'd1);
      chk("illegal busy", 64'(bsy[q]), 64'd0);
    end
    chk("illegal data held", dout[0], pd);
    chk("illegal ready held", 64'(rdy[0]), pr);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("illegal err drop", 64'(err[0]), 64'd0);
    chk("illegal still idle", 64'(bsy[0]), 64'd0);

    // async reset partway through a run
    go("pre-reset", tv[0], 1'b0);
    @(negedge clock);
    mode = ECB; enc = 1'b1; key = KEY; data = PT;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    for (int q = 0; q < 3; q++) begin
      chk("mid reset busy", 64'(bsy[q]), 64'd0);
      chk("mid reset ready", 64'(rdy[q]), 64'd0);
      chk("mid reset data", dout[q], 64'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    hv = '{CBC, 1'b1, 1'b0, 64'd0, KEY, PT, CT};
    go("post-reset cbc chain0", hv, 1'b0);
    go("post-reset ecb", tv[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
